// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline package: pipeline register typedefs, stall FSM encoding
// and the NOP instruction word used when IF/ID is flushed.
package pipe_stall_ctrl_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } signal;

  typedef struct packed {
    signal       sig;
    logic [31:0] inst;
    logic [31:0] pc;
  } PipReg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZ    = 2'd1,
    FREEZE = 2'd2,
    ERR    = 2'd3
  } stall_state_e;

  localparam logic [31:0] NOP_INST = 32'h0;

  // Stall kind requested this cycle; memory freeze outranks the hazard stall.
  function automatic stall_state_e stall_kind(input logic mem_busy, input logic risk);
    if (mem_busy) return FREEZE;
    if (risk)     return HAZ;
    return RUN;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with stall-episode FSM and watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int WD_LIMIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             risk,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             redirect,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic [1:0]       stall_state,
  output logic             wd_trip,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int             WD_W   = $clog2(WD_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT - 1);

  stall_state_e    state, state_nxt, req_state;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            trip_nxt;

  // Level controls; reset forces the normal (free-running) pattern.
  always_comb begin
    pc_en        = 1'b1;
    redirect     = 1'b0;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else if (risk) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (branch_taken || jump) begin
        redirect   = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  // Watchdog counts only while the same stall kind persists; a trip is sticky.
  always_comb begin
    req_state = stall_kind(mem_busy, risk);
    state_nxt = req_state;
    wd_nxt    = '0;
    trip_nxt  = wd_trip;
    case (state)
      ERR: begin
        state_nxt = ERR;
      end
      HAZ, FREEZE: begin
        if (req_state == state) begin
          if (wd_cnt == WD_MAX) begin
            state_nxt = ERR;
            trip_nxt  = 1'b1;
          end else begin
            wd_nxt = wd_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      wd_cnt  <= '0;
      wd_trip <= 1'b0;
    end else begin
      state   <= state_nxt;
      wd_cnt  <= wd_nxt;
      wd_trip <= trip_nxt;
    end
  end

  assign stall_state = state;

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (!pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (ifid_flush),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer end of the hazard/stall interface for the 5-stage MIPS pipeline.
- Takes the hazard-detection `Risk` request, ID-stage branch/jump redirects and the data-memory busy signal.
- Drives the per-stage enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks stall episodes in a small FSM with a watchdog, so a stuck hazard is detected rather than hanging silently.

Parameters:
- WD_LIMIT, 64: maximum consecutive stall cycles (HAZ or FREEZE) before watchdog trips.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- risk  in  1  stall request from hazard detection (load-use, branch operand not ready)
- branch_taken  in  1  ID-stage branch resolved taken
- jump  in  1  ID-stage j/jal/jr
- mem_busy  in  1  data memory not ready; MEM stage must hold
- pc_en  out  1  PC register load enable
- redirect  out  1  PC mux selects branch/jump target
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads NOP (sig cleared, inst=0)
- idex_bubble  out  1  ID/EX loads bubble (all sig fields 0)
- idex_en  out  1  ID/EX register enable
- exmem_en  out  1  EX/MEM register enable
- memwb_bubble  out  1  MEM/WB loads bubble
- stall_state  out  2  FSM state encoding
- wd_trip  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  stall cycles (feature-gated)
- flush_cnt  out  CNT_W  redirect flushes (feature-gated)

Behaviour:
- Control outputs are combinational from the current inputs; the FSM, watchdog and counters are registered.
- Priority, highest first: mem_busy > risk > (branch_taken|jump) > normal.
- Normal:
  - pc_en=ifid_en=idex_en=exmem_en=1; all flush/bubble/redirect=0.
- mem_busy=1 (freeze):
  - pc_en=ifid_en=idex_en=exmem_en=0; memwb_bubble=1; idex_bubble=0.
  - risk, branch_taken and jump are ignored; the instruction stays in ID and re-presents after the freeze.
- risk=1, mem_busy=0 (hazard stall):
  - pc_en=ifid_en=0; idex_en=1; idex_bubble=1; exmem_en=1.
  - branch_taken/jump ignored, since their operands are not valid.
- Redirect, when (branch_taken|jump)=1, risk=0, mem_busy=0:
  - pc_en=1; redirect=1; ifid_flush=1; ifid_en=1; no ID/EX bubble.
- FSM states: RUN=0, HAZ=1, FREEZE=2, ERR=3.
  - Next state is FREEZE if mem_busy, else HAZ if risk, else RUN.
  - ERR is entered from HAZ/FREEZE when the watchdog count reaches WD_LIMIT-1 and the stall condition persists next cycle.
  - ERR is left only on rst.
  - In ERR the controls still follow the priority rules above (observational only).
- Watchdog:
  - Counter, width clog2(WD_LIMIT)+1, cleared on RUN, on any state change, and on reset.
  - Increments each cycle in HAZ/FREEZE.
  - wd_trip goes high the cycle ERR is entered and stays high until rst.
- Boundary cases:
  - HAZ→FREEZE directly clears the watchdog count.
  - A stall of exactly WD_LIMIT cycles does not trip.
- Reset:
  - State=RUN, watchdog=0, wd_trip=0, counters=0.
  - While rst=1, outputs are those of the normal case.
  - Reset mid-stall returns to RUN the next cycle regardless of inputs.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle where pc_en=0.
  - flush_cnt increments every cycle where ifid_flush=1.
  - Both saturate at all-ones and clear on rst.
- Undefined:
  - Counter logic is removed; stall_cnt and flush_cnt are tied to 0.

Decomposition:
- Shared pipeline package holds:
  - the existing `signal`/`PipReg` typedefs;
  - the stall_state enum (RUN/HAZ/FREEZE/ERR);
  - the NOP instruction constant (32'h0).
- One sub-module: sat_counter (CNT_W, inc, clr), instantiated twice when the feature is enabled.

Test Plan:
- Single load-use, risk=1 for 1 cycle → pc_en=0, ifid_en=0, idex_bubble=1 that cycle; stall_state goes RUN→HAZ→RUN.
- branch_taken=1 with risk=0 → redirect=1, ifid_flush=1, pc_en=1; flush_cnt 0→1 with the feature on.
- mem_busy=1 for 3 cycles with risk=1 and branch_taken=1 → all enables 0, memwb_bubble=1, redirect=0; FREEZE held 3 cycles, then HAZ when mem_busy drops.
- risk held 64 cycles → wd_trip stays 0; risk held 65 cycles → wd_trip=1, stall_state=ERR; rst=1 for one cycle → RUN, wd_trip=0.
- rst asserted mid-FREEZE with mem_busy still 1 → during rst the outputs are normal-case; next cycle state is RUN, then FREEZE.
- Feature on, 10 stall cycles and 2 flushes → stall_cnt=10, flush_cnt=2; feature off → both read 0.
